// File: rtl/timer_counter.sv
// timer_counter: memory-mapped countdown timer feeding CP0 HWInt[0].
// Registers: CTRL (offset 0), PRESET (offset 1), COUNT (offset 2, read-only).
// CTRL = {28'b0, IM, Mode[1:0], Enable}. IRQ = irq_flag & IM.
// Optional feature macro: TIMER_MODE1_EN enables auto-reload (Mode == 01).
// Without it every Mode value behaves as one-shot; Mode bits are still stored.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_PRESET = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;

  logic [1:0]  state;
  logic        ctrl_enable;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  logic        auto_reload;

`ifdef TIMER_MODE1_EN
  assign auto_reload = (ctrl_mode == 2'b01);
`else
  assign auto_reload = 1'b0;
`endif

  assign IRQ = irq_flag & ctrl_im;

  // Read mux: purely combinational view of the current register state.
  always_comb begin
    DOut = 32'd0;
    case (Addr)
      OFS_CTRL:   DOut = {28'd0, ctrl_im, ctrl_mode, ctrl_enable};
      OFS_PRESET: DOut = preset;
      OFS_COUNT:  DOut = count;
      default:    DOut = 32'd0;
    endcase
  end

  // FSM and register update; bus writes are applied after the FSM so they win.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ctrl_enable <= 1'b0;
      ctrl_mode   <= 2'b00;
      ctrl_im     <= 1'b0;
      preset      <= 32'd0;
      count       <= 32'd0;
      irq_flag    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl_enable) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl_enable) begin
            state <= ST_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count    <= 32'd0;
            irq_flag <= 1'b1;
            state    <= ST_INT;
          end
        end
        ST_INT: begin
          if (auto_reload) begin
            count    <= preset;
            irq_flag <= 1'b0;
            state    <= ST_CNT;
          end else begin
            ctrl_enable <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (We) begin
        case (Addr)
          OFS_CTRL: begin
            ctrl_enable <= DIn[0];
            ctrl_mode   <= DIn[2:1];
            ctrl_im     <= DIn[3];
            irq_flag    <= 1'b0;
          end
          OFS_PRESET: begin
            preset   <= DIn;
            irq_flag <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
